start_done_responder: RTL and testbench
=======================================

Name: start_done_responder

Overview:
- Responder end of the start/done handshake used by the CPU's top-level sequencing state machine.
- The initiator raises `start`. This block runs one instruction step: a FETCH cycle, a DECODE cycle, then EXECUTE for a programmable number of cycles.
- It then raises `done` and holds it until the initiator drops `start` (4-phase, return-to-zero).
- It also keeps a count of completed steps and a sticky protocol-error flag.

Parameters:
- LAT_W, 4, width of the `exec_lat` input (EXECUTE cycle count).
- CNT_W, 8, width of `op_count`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  handshake request from the initiator, level-sensitive.
- exec_lat  in  LAT_W  EXECUTE duration in cycles; sampled only on IDLE->FETCH.
- done  out  1  handshake acknowledge, registered.
- busy  out  1  high in FETCH, DECODE, EXECUTE.
- state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, DONE=4.
- op_count  out  CNT_W  number of completed steps.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (`rst_n`=0, asynchronous, any state): state=IDLE, done=0, busy=0, op_count=0, err=0, internal latency counter=0. Outputs go to these values immediately, not at the next edge.
- All outputs are registered, or decoded from the state register only. No combinational path from `start` to `done`.
- IDLE:
  - done=0, busy=0.
  - `start`=1 at an edge -> FETCH. The same edge loads lat_cnt = max(`exec_lat`, 1); `exec_lat`=0 is treated as 1.
  - `start`=0 -> stay in IDLE.
- FETCH: 1 cycle -> DECODE.
- DECODE: 1 cycle -> EXECUTE.
- EXECUTE:
  - Each edge decrements lat_cnt.
  - When lat_cnt==1 at an edge -> DONE, so EXECUTE lasts exactly max(`exec_lat`,1) cycles.
- DONE:
  - done=1, busy=0.
  - On the entering edge, op_count increments by 1, wrapping modulo 2^CNT_W (255 -> 0 at default).
  - Stay while `start`=1.
  - `start`=0 at an edge -> IDLE; done=0 from that edge.
- Latency: if edge E0 samples `start`=1 in IDLE, `done` rises after edge E0+2+max(`exec_lat`,1).
- Protocol violation (`start`=0 sampled in FETCH, DECODE or EXECUTE):
  - err is set to 1 and stays 1 until reset.
  - State -> IDLE at that edge.
  - done stays 0 and op_count is not incremented.
- New request:
  - A new request is only recognised in IDLE, which is reachable only after `start` has been seen low.
  - A `start` held high continuously therefore yields exactly one step.
  - Re-raising `start` the cycle after IDLE is entered is legal and starts a new step.
- `exec_lat` changes after sampling have no effect on the step in progress.
- Reset asserted mid-step: the step is abandoned, no done, counters and err cleared.
- Illegal state encodings (5-7) -> IDLE at the next edge. done=0 and err is unchanged.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> state=0, done=0, busy=0, op_count=0, err=0.
- Basic step: release reset, exec_lat=3, start=1 sampled at E0.
  - Required: state 1,2,3,3,3 after E0..E4.
  - done=1 and state=4 after E5; op_count=1; busy=1 after E0..E4, 0 after E5.
  - Hold start=1 for 10 more cycles -> done stays 1, op_count stays 1.
  - Drop start -> done=0 and state=0 after next edge.
- Zero latency: exec_lat=0 -> done rises after E0+3, identical to exec_lat=1.
- Protocol violation: start=1 at E0, start=0 at E3 (EXECUTE, exec_lat=5).
  - Required: state=0 and err=1 after E3; done never rises; op_count unchanged.
  - A following normal step completes with err still 1.
- Wrap and back-to-back: 256 steps with exec_lat=1 and start re-raised the cycle after IDLE.
  - Required: op_count=0 after step 256.
  - Each step's done rises exactly 3 edges after the sampling edge.
- Async reset mid-EXECUTE: pulse rst_n low between edges.
  - Required: state=0, op_count=0, err=0 before the next clk edge; done never asserted for that step.

Source files
------------

// File: rtl/start_done_responder.sv
// -----------------------------------------------------------------------------
// start_done_responder
//
// Responder side of a 4-phase (return-to-zero) start/done handshake. On a
// request it runs one instruction step: one FETCH cycle, one DECODE cycle,
// then EXECUTE for max(exec_lat,1) cycles. It then raises done and holds it
// until start is dropped. It also keeps a wrapping count of completed steps
// and a sticky protocol-error flag.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   handshake request (level)
//   exec_lat  in   EXECUTE length in cycles, sampled on IDLE->FETCH only
//   done      out  handshake acknowledge (decoded from the state register)
//   busy      out  high in FETCH, DECODE and EXECUTE
//   state     out  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, DONE=4
//   op_count  out  completed-step counter, wraps modulo 2^CNT_W
//   err       out  sticky flag: start was dropped mid-step
// -----------------------------------------------------------------------------
module start_done_responder #(
    parameter int LAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LAT_W-1:0] exec_lat,
    output logic             done,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] op_count,
    output logic             err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       state_q,    state_d;
    logic [LAT_W-1:0] lat_cnt_q,  lat_cnt_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             err_q,      err_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lat_cnt_q  <= '0;
            op_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            op_count_q <= op_count_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        op_count_d = op_count_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    // A zero latency still spends one cycle in EXECUTE.
                    lat_cnt_d = (exec_lat == '0) ? LAT_W'(1) : exec_lat;
                end
            end
            S_FETCH: begin
                if (!start) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!start) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (!start) begin
                    // Initiator abandoned the step: flag it, never acknowledge.
                    state_d   = S_IDLE;
                    err_d     = 1'b1;
                    lat_cnt_d = '0;
                end else if (lat_cnt_q <= LAT_W'(1)) begin
                    // <= also drains a corrupted zero count instead of
                    // running a full wrap-around.
                    state_d    = S_DONE;
                    lat_cnt_d  = '0;
                    op_count_d = op_count_q + CNT_W'(1);
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_DONE: begin
                // Return-to-zero: only a low start releases the acknowledge.
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                lat_cnt_d = '0;
            end
        endcase
    end

    // Outputs decoded from the state register only, so start never reaches
    // done combinationally.
    always_comb begin
        done = (state_q == S_DONE);
        busy = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE);
    end

    assign state    = state_q;
    assign op_count = op_count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_start_done_responder.sv
// -----------------------------------------------------------------------------
// tb_start_done_responder
//
// Directed scenarios followed by randomized start/exec_lat/reset stimulus,
// all compared every cycle against a step-level reference model that tracks
// only "idle / running k edges into a step of length L / acknowledging".
// -----------------------------------------------------------------------------
module tb_start_done_responder;

    localparam int LAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LAT_W-1:0] exec_lat;
    logic             done;
    logic             busy;
    logic [2:0]       state;
    logic [CNT_W-1:0] op_count;
    logic             err;

    start_done_responder #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .exec_lat (exec_lat),
        .done     (done),
        .busy     (busy),
        .state    (state),
        .op_count (op_count),
        .err      (err)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: phase 0 = idle, 1 = step running, 2 = acknowledging.
    int m_phase;
    int m_k;      // edges since the request was accepted (0 right after it)
    int m_len;    // EXECUTE length of the current step
    int m_count;
    int m_err;
    int m_steps;  // completed steps, for the log only

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_k     = 0;
        m_len   = 0;
        m_count = 0;
        m_err   = 0;
    endtask

    // One rising edge of the protocol, using the inputs the edge sees.
    task automatic model_edge();
        case (m_phase)
            0: if (start) begin
                m_phase = 1;
                m_k     = 0;
                m_len   = (int'(exec_lat) < 1) ? 1 : int'(exec_lat);
            end
            1: if (!start) begin
                m_phase = 0;
                m_err   = 1;
            end else begin
                m_k++;
                // FETCH + DECODE + m_len EXECUTE cycles have elapsed
                if (m_k == 2 + m_len) begin
                    m_phase = 2;
                    m_count = (m_count + 1) % (1 << CNT_W);
                    m_steps++;
                    $display("step %0d: exec_len %0d op_count %0d err %0d t=%0t",
                             m_steps, m_len, m_count, m_err, $time);
                end
            end
            default: if (!start) m_phase = 0;
        endcase
    endtask

    function automatic int exp_state();
        if (m_phase == 0) return 0;
        if (m_phase == 2) return 4;
        if (m_k == 0) return 1;
        if (m_k == 1) return 2;
        return 3;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".state"},    32'(state),    32'(exp_state()));
        chk({tag, ".done"},     32'(done),     32'(m_phase == 2));
        chk({tag, ".busy"},     32'(busy),     32'(m_phase == 1));
        chk({tag, ".op_count"}, 32'(op_count), 32'(m_count));
        chk({tag, ".err"},      32'(err),      32'(m_err));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    // Pulse reset between edges (called just after a falling edge).
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    // Raise start with the given latency, wait (bounded) for done and check
    // how many edges after the sampling edge it rose. Leaves start high.
    task automatic run_step(input string tag, input int lat);
        int n;
        int want;
        start    = 1'b1;
        exec_lat = LAT_W'(lat);
        n = 0;
        want = 2 + ((lat < 1) ? 1 : lat);
        for (int i = 0; i < 40; i++) begin
            cyc(tag);
            if (done) break;
            n++;
        end
        chk({tag, ".done_latency"}, 32'(n), 32'(want));
    endtask

    initial begin
        m_steps = 0;
        model_reset();

        // Reset held with start high
        rst_n = 1'b0;
        start = 1'b1;
        exec_lat = 4'd3;
        #1;
        check_all("reset");
        repeat (3) begin
            @(negedge clk);
            check_all("reset_hold");
        end
        start = 1'b0;
        rst_n = 1'b1;
        cyc("idle");

        // Basic step, exec_lat=3, then a long hold of start
        run_step("basic", 3);
        chk("basic.count", 32'(op_count), 32'd1);
        exec_lat = 4'd9;   // must not matter any more
        repeat (10) cyc("basic_hold");
        start = 1'b0;
        cyc("basic_release");
        chk("basic.released", 32'(done), 32'd0);

        // Zero latency behaves like one
        run_step("lat0", 0);
        start = 1'b0;
        cyc("lat0_release");
        run_step("lat1", 1);
        start = 1'b0;
        cyc("lat1_release");

        // Protocol violation in EXECUTE
        start = 1'b1;
        exec_lat = 4'd5;
        cyc("viol_e0");
        cyc("viol_e1");
        cyc("viol_e2");
        start = 1'b0;
        cyc("viol_e3");
        chk("viol.err", 32'(err), 32'd1);
        repeat (4) cyc("viol_idle");
        run_step("after_viol", 2);
        start = 1'b0;
        cyc("after_viol_release");

        // Wrap and back-to-back steps
        async_reset("pre_wrap_rst");
        for (int s = 0; s < 256; s++) begin
            run_step("wrap", 1);
            start = 1'b0;
            cyc("wrap_release");
        end
        chk("wrap.count", 32'(op_count), 32'd0);

        // Reset in the middle of EXECUTE
        start = 1'b1;
        exec_lat = 4'd6;
        repeat (4) cyc("mid_exec");
        async_reset("mid_exec_rst");
        start = 1'b0;
        repeat (3) cyc("after_rst");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 2) start = ~start;
            if ($urandom_range(0, 3) == 0) exec_lat = LAT_W'($urandom);
            cyc("rand");
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
